// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit FIFO
//
// Purpose : controller state encoding and default data width, imported by the
//           interface and the top-level uart_tx_fifo.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        WAIT_IDLE = 2'd3
    } txf_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host/transmitter signal bundle for uart_tx_fifo
//
// Purpose : groups the host write port, FIFO flags and transmitter handshake.
// Signals : wr_en, wr_data   host write strobe and byte
//           full, empty      FIFO occupancy flags
//           tx_done          transmitter stop-bit status
//           tx_start, din    launch pulse and byte to the transmitter
//           tx_busy          controller not idle
//           ovf_clr, ovf     sticky overflow flag and its clear
//                            (only when UART_TX_FIFO_OVF_EN is defined)
// Modports: master = host/transmitter side, slave = uart_tx_fifo.
interface uart_tx_fifo_if import uart_pkg::*; #(
    parameter int N = UART_DATA_W
) ();

    logic         wr_en;
    logic [N-1:0] wr_data;
    logic         full;
    logic         empty;
    logic         tx_done;
    logic         tx_start;
    logic [N-1:0] din;
    logic         tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic         ovf_clr;
    logic         ovf;

    modport master (
        output wr_en, wr_data, tx_done, ovf_clr,
        input  full, empty, tx_start, din, tx_busy, ovf
    );

    modport slave (
        input  wr_en, wr_data, tx_done, ovf_clr,
        output full, empty, tx_start, din, tx_busy, ovf
    );
`else
    modport master (
        output wr_en, wr_data, tx_done,
        input  full, empty, tx_start, din, tx_busy
    );

    modport slave (
        input  wr_en, wr_data, tx_done,
        output full, empty, tx_start, din, tx_busy
    );
`endif

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock circular-buffer FIFO with registered flags
//
// Purpose : storage for queued bytes. Pointers carry one extra MSB so that
//           equal low bits with differing MSBs means full.
// Ports   : clk, rst         clock, synchronous active-high reset
//           i_wr_en          push request (ignored while full)
//           i_wr_data        byte to push
//           i_rd_en          pop request (ignored while empty)
//           o_rd_data        head entry, valid while not empty
//           o_full, o_empty  registered occupancy flags
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         r_full;
    logic         r_empty;

    logic         w_wr_ok;
    logic         w_rd_ok;
    logic [AW:0]  w_wptr_nxt;
    logic [AW:0]  w_rptr_nxt;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign w_wr_ok = i_wr_en && !r_full;
    assign w_rd_ok = i_rd_en && !r_empty;

    always_comb begin
        w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_wr_ok};
        w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_rd_ok};
    end

    // Flags are computed from the next pointers so they change the cycle
    // after the causing write or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rptr[AW-1:0]];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO and launch controller for the UART
//
// Purpose : queues host bytes and launches them one at a time into the UART
//           transmitter, pacing on tx_done.
// Ports   : clk      clock, rising edge
//           rst      synchronous active-high reset
//           bus      uart_tx_fifo_if.slave (wr_en/wr_data in, full/empty out,
//                    tx_done in, tx_start/din/tx_busy out)
// Options : UART_TX_FIFO_OVF_EN adds bus.ovf_clr/bus.ovf, a sticky flag set by
//           any write attempted while full.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int N          = UART_DATA_W,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_fifo_if.slave   bus
);

    txf_state_t   r_state;
    txf_state_t   w_state_nxt;
    logic         r_tx_start;
    logic [N-1:0] r_din;

    logic         w_pop;
    logic [N-1:0] w_head;
    logic         w_full;
    logic         w_empty;

    sync_fifo #(
        .W  (N),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.wr_en),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // The pop happens on the IDLE->LAUNCH edge, together with loading din.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH:    w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.tx_done)  w_state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (!bus.tx_done) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // tx_start is registered alongside the state, so it is high exactly while
    // the state is LAUNCH; LAUNCH always exits after one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_din      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= (w_state_nxt == LAUNCH);
            if (w_pop) begin
                r_din <= w_head;
            end
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.tx_start = r_tx_start;
    assign bus.din      = r_din;
    assign bus.tx_busy  = (r_state != IDLE);

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    // Set wins over clear when both occur in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.wr_en && w_full) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uart_tx_fifo_if #(.N(8)) bus ();

    uart_tx_fifo #(.N(8), .DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_done;
        logic       e_full;
        logic       e_empty;
        logic       e_start;
        logic [7:0] e_din;
        logic       e_busy;
    } vec_t;

    vec_t vecs [8];
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    // Plays the transmitter for one frame: optionally waits for the launch,
    // captures din, then raises tx_done for the stop bit and drops it.
    task automatic serve(input bit launched, input bit chk_gap, output logic [7:0] b);
        int n;
        n = 0;
        if (!launched) begin
            while (bus.tx_start !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("launch_seen", {31'd0, bus.tx_start}, 32'd1);
            if (chk_gap) check("launch_gap", n, 32'd2);
        end
        b = bus.din;
        @(negedge clk);
        if (!launched) check("start_one_cycle", {31'd0, bus.tx_start}, 32'd0);
        check("busy_in_frame", {31'd0, bus.tx_busy}, 32'd1);
        repeat (3) @(negedge clk);
        bus.tx_done = 1'b1;
        repeat (2) @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         starts;

        //        wr  data   done full empty start din    busy
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_done = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        bus.ovf_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
`ifdef UART_TX_FIFO_OVF_EN
        check("reset_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        rst = 1'b0;

        // Single byte, cycle by cycle.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("row%0d_full", i),  {31'd0, bus.full},     {31'd0, vecs[i].e_full});
            check($sformatf("row%0d_empty", i), {31'd0, bus.empty},    {31'd0, vecs[i].e_empty});
            check($sformatf("row%0d_start", i), {31'd0, bus.tx_start}, {31'd0, vecs[i].e_start});
            check($sformatf("row%0d_din", i),   {24'd0, bus.din},      {24'd0, vecs[i].e_din});
            check($sformatf("row%0d_busy", i),  {31'd0, bus.tx_busy},  {31'd0, vecs[i].e_busy});
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].wr_data;
            bus.tx_done = vecs[i].tx_done;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;

        // Burst 0x01..0x05; the first launch happens while still writing.
        for (int i = 0; i < 5; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i + 1);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        serve(1'b1, 1'b0, b);
        check("burst_b0", {24'd0, b}, 32'h01);
        for (int i = 1; i < 5; i++) begin
            serve(1'b0, 1'b1, b);
            check($sformatf("burst_b%0d", i), {24'd0, b}, 32'(i + 1));
        end
        check("burst_empty_end", {31'd0, bus.empty}, 32'd1);
        repeat (3) @(negedge clk);
        check("burst_idle_end", {31'd0, bus.tx_busy}, 32'd0);

        // Full/overflow: park the controller in WAIT_DONE with one byte,
        // then offer 17 more.
        write_byte(8'hEE);
        repeat (2) @(negedge clk);
        check("full_primed_busy", {31'd0, bus.tx_busy}, 32'd1);
        for (int i = 0; i < 17; i++) begin
            if (i == 15) check("full_before_16th", {31'd0, bus.full}, 32'd0);
            if (i == 16) check("full_after_16th",  {31'd0, bus.full}, 32'd1);
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("full_after_17th", {31'd0, bus.full}, 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_set", {31'd0, bus.ovf}, 32'd1);
        @(negedge clk);
        check("ovf_held", {31'd0, bus.ovf}, 32'd1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, bus.ovf}, 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hFF;
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        check("ovf_set_beats_clr", {31'd0, bus.ovf}, 32'd1);
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check("ovf_cleared2", {31'd0, bus.ovf}, 32'd0);
`endif
        serve(1'b1, 1'b0, b);
        check("drain_primed", {24'd0, b}, 32'hEE);
        for (int i = 0; i < 16; i++) begin
            serve(1'b0, 1'b1, b);
            check($sformatf("drain_b%0d", i), {24'd0, b}, 32'(8'h10 + i));
        end
        check("drain_empty_end", {31'd0, bus.empty}, 32'd1);
        repeat (3) @(negedge clk);

        // Write lands on the pop edge: occupancy stays at one.
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h5A;
        @(negedge clk);
        bus.wr_data = 8'hC3;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("simul_start", {31'd0, bus.tx_start}, 32'd1);
        check("simul_din",   {24'd0, bus.din},      32'h5A);
        check("simul_empty", {31'd0, bus.empty},    32'd0);
        @(negedge clk);
        check("simul_empty2", {31'd0, bus.empty}, 32'd0);
        serve(1'b1, 1'b0, b);
        check("simul_b0", {24'd0, b}, 32'h5A);
        serve(1'b0, 1'b1, b);
        check("simul_b1", {24'd0, b}, 32'hC3);
        check("simul_empty_end", {31'd0, bus.empty}, 32'd1);
        repeat (3) @(negedge clk);

        // Pointer wrap: 40 random bytes with random write gaps.
        fork
            begin : writer
                for (int i = 0; i < 40; i++) begin
                    int n;
                    logic [7:0] d;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    n = 0;
                    while (bus.full && n < 500) begin
                        @(negedge clk);
                        n++;
                    end
                    d = 8'($urandom);
                    exp_q.push_back(d);
                    write_byte(d);
                end
            end
            begin : server
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] e;
                    logic [7:0] g;
                    serve(1'b0, 1'b0, g);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                    check($sformatf("wrap_b%0d", i), {24'd0, g}, {24'd0, e});
                end
            end
        join
        check("wrap_empty_end", {31'd0, bus.empty}, 32'd1);
        repeat (3) @(negedge clk);

        // Reset while in WAIT_DONE with three bytes queued.
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h31 + i);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("rst_pre_busy",  {31'd0, bus.tx_busy}, 32'd1);
        check("rst_pre_empty", {31'd0, bus.empty},   32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_empty", {31'd0, bus.empty},    32'd1);
        check("rst_busy",  {31'd0, bus.tx_busy},  32'd0);
        check("rst_start", {31'd0, bus.tx_start}, 32'd0);
        check("rst_full",  {31'd0, bus.full},     32'd0);
        check("rst_din",   {24'd0, bus.din},      32'h00);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) starts++;
        end
        check("rst_no_launch", starts, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
